// File: rtl/bp_lce_mem_port_sched_if.sv
// Handshake bundle between the port scheduler and its two requesters plus
// the memory port it drives.
//   cache_pkt_v_i / cache_pkt_i / cache_pkt_yumi_o : cache pipeline request
//   lce_pkt_v_i / lce_pkt_i / lce_lock_i / lce_pkt_yumi_o : LCE request
//   mem_pkt_v_o / mem_pkt_o / mem_ready_and_i / mem_sel_lce_o : memory side
//   cache_busy_o : cache must not issue
//   starve_cnt_o : LCE starvation count
// The slave modport belongs to the scheduler; the master modport belongs to
// the environment (requesters and memory).
interface bp_lce_mem_port_sched_if #(
   parameter int pkt_width_p         = 8,
   parameter int timeout_max_limit_p = 4
);
   localparam int cnt_width_lp = $clog2(timeout_max_limit_p + 1);

   logic                    cache_pkt_v_i;
   logic [pkt_width_p-1:0]  cache_pkt_i;
   logic                    cache_pkt_yumi_o;
   logic                    lce_pkt_v_i;
   logic [pkt_width_p-1:0]  lce_pkt_i;
   logic                    lce_lock_i;
   logic                    lce_pkt_yumi_o;
   logic                    mem_pkt_v_o;
   logic [pkt_width_p-1:0]  mem_pkt_o;
   logic                    mem_ready_and_i;
   logic                    mem_sel_lce_o;
   logic                    cache_busy_o;
   logic [cnt_width_lp-1:0] starve_cnt_o;

   modport master (
      output cache_pkt_v_i, cache_pkt_i, lce_pkt_v_i, lce_pkt_i, lce_lock_i, mem_ready_and_i,
      input  cache_pkt_yumi_o, lce_pkt_yumi_o, mem_pkt_v_o, mem_pkt_o, mem_sel_lce_o,
             cache_busy_o, starve_cnt_o
   );

   modport slave (
      input  cache_pkt_v_i, cache_pkt_i, lce_pkt_v_i, lce_pkt_i, lce_lock_i, mem_ready_and_i,
      output cache_pkt_yumi_o, lce_pkt_yumi_o, mem_pkt_v_o, mem_pkt_o, mem_sel_lce_o,
             cache_busy_o, starve_cnt_o
   );
endinterface

// File: rtl/bp_lce_mem_port_sched.sv
// Two-requester scheduler for one cache memory port (tag, data or stat).
// The cache pipeline has default priority; the LCE takes the port when it
// has starved for timeout_max_limit_p cycles, and may hold it across a
// multi-packet sequence via lce_lock_i.
// Ports:
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset; forces all outputs to 0
//   sched_if   : slave side of bp_lce_mem_port_sched_if (requests, memory
//                handshake, cache_busy_o, starve_cnt_o)
module bp_lce_mem_port_sched #(
   parameter int pkt_width_p         = 8,
   parameter int timeout_max_limit_p = 4
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   bp_lce_mem_port_sched_if.slave sched_if
);
   localparam int cnt_width_lp = $clog2(timeout_max_limit_p + 1);
   localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(timeout_max_limit_p);
   localparam logic [cnt_width_lp-1:0] cnt_trig_lp = cnt_width_lp'(timeout_max_limit_p - 1);

   typedef enum logic [1:0] {
      PRIO_CACHE,
      STARVE,
      LOCK
   } state_e;

   state_e                  state_r;
   logic [cnt_width_lp-1:0] cnt_r;

   logic lce_excl;
   logic cache_own;
   logic lce_own;
   logic cache_yumi;
   logic lce_yumi;
   logic lce_blocked;

   always_comb begin
      lce_excl    = (state_r != PRIO_CACHE);
      cache_own   = sched_if.cache_pkt_v_i & ~lce_excl;
      lce_own     = sched_if.lce_pkt_v_i & (lce_excl | ~sched_if.cache_pkt_v_i);
      // Handshakes are gated by reset so nothing is consumed while reset is held.
      cache_yumi  = reset_n_i & cache_own & sched_if.mem_ready_and_i;
      lce_yumi    = reset_n_i & lce_own & sched_if.mem_ready_and_i;
      lce_blocked = sched_if.lce_pkt_v_i & ~lce_yumi;
   end

   assign sched_if.cache_pkt_yumi_o = cache_yumi;
   assign sched_if.lce_pkt_yumi_o   = lce_yumi;
   assign sched_if.mem_pkt_v_o      = reset_n_i & (cache_own | lce_own);
   assign sched_if.mem_sel_lce_o    = reset_n_i & lce_own;
   // With no owner the cache packet is passed through, matching a sel of 0.
   assign sched_if.mem_pkt_o        = reset_n_i ? (lce_own ? sched_if.lce_pkt_i : sched_if.cache_pkt_i) : '0;
   // Pure state decode; the asynchronous reset already forces PRIO_CACHE.
   assign sched_if.cache_busy_o     = lce_excl;
   assign sched_if.starve_cnt_o     = cnt_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= PRIO_CACHE;
         cnt_r   <= '0;
      end else begin
         if (lce_blocked) begin
            cnt_r <= (cnt_r == cnt_max_lp) ? cnt_r : cnt_r + cnt_width_lp'(1);
         end else begin
            cnt_r <= '0;
         end

         case (state_r)
            PRIO_CACHE: begin
               if (lce_yumi & sched_if.lce_lock_i) begin
                  state_r <= LOCK;
               end else if (lce_blocked & (cnt_r == cnt_trig_lp)) begin
                  state_r <= STARVE;
               end
            end
            STARVE: begin
               if (lce_yumi) begin
                  state_r <= sched_if.lce_lock_i ? LOCK : PRIO_CACHE;
               end else if (!sched_if.lce_pkt_v_i) begin
                  // Withdrawn LCE request: give the port back to the cache.
                  state_r <= PRIO_CACHE;
               end
            end
            LOCK: begin
               if (lce_yumi & ~sched_if.lce_lock_i) begin
                  state_r <= PRIO_CACHE;
               end
            end
            default: state_r <= PRIO_CACHE;
         endcase
      end
   end

   a_cache_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      sched_if.cache_pkt_yumi_o |-> sched_if.cache_pkt_v_i);
   a_lce_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      sched_if.lce_pkt_yumi_o |-> sched_if.lce_pkt_v_i);
   a_lce_valid_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (sched_if.lce_pkt_v_i && !sched_if.lce_pkt_yumi_o) |=> sched_if.lce_pkt_v_i);
   a_cache_yumi_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(sched_if.cache_pkt_yumi_o && sched_if.cache_busy_o));
endmodule

// File: tb/tb_bp_lce_mem_port_sched.sv
module tb_bp_lce_mem_port_sched;
   localparam int W   = 8;
   localparam int MAX = 4;
   localparam int CW  = $clog2(MAX + 1);
   localparam int OW  = 5 + CW + W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   bp_lce_mem_port_sched_if #(.pkt_width_p(W), .timeout_max_limit_p(MAX)) bus ();
   bp_lce_mem_port_sched_if #(.pkt_width_p(W), .timeout_max_limit_p(1))   bus1 ();

   bp_lce_mem_port_sched #(.pkt_width_p(W), .timeout_max_limit_p(MAX)) dut0 (
      .clk_i(clk), .reset_n_i(rst_n), .sched_if(bus));
   bp_lce_mem_port_sched #(.pkt_width_p(W), .timeout_max_limit_p(1)) dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .sched_if(bus1));

   // Reference model: LCE exclusivity flags and a wait counter.
   bit          m_locked;
   bit          m_forced;
   int          m_wait;
   logic [OW-1:0] e_vec;
   bit          e_ly;

   function automatic logic [OW-1:0] obs0();
      return {bus.cache_pkt_yumi_o, bus.lce_pkt_yumi_o, bus.mem_pkt_v_o, bus.mem_sel_lce_o,
              bus.cache_busy_o, bus.starve_cnt_o, bus.mem_pkt_o};
   endfunction

   task automatic apply(input bit cv, input logic [W-1:0] cp, input bit lv,
                        input logic [W-1:0] lp, input bit lk, input bit rdy);
      bus.cache_pkt_v_i   = cv;
      bus.cache_pkt_i     = cp;
      bus.lce_pkt_v_i     = lv;
      bus.lce_pkt_i       = lp;
      bus.lce_lock_i      = lk;
      bus.mem_ready_and_i = rdy;
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_forced = 0;
      m_wait   = 0;
   endtask

   task automatic model_eval();
      bit excl, lh, ch;
      logic [W-1:0] pk;
      excl = m_locked || m_forced;
      lh   = bus.lce_pkt_v_i && (excl || !bus.cache_pkt_v_i);
      ch   = bus.cache_pkt_v_i && !excl;
      pk   = lh ? bus.lce_pkt_i : bus.cache_pkt_i;
      e_ly = lh && bus.mem_ready_and_i;
      e_vec = {ch && bus.mem_ready_and_i, e_ly, lh || ch, lh, excl, CW'(m_wait), pk};
   endtask

   task automatic model_advance();
      bit lv, lk, blocked;
      lv = bus.lce_pkt_v_i;
      lk = bus.lce_lock_i;
      blocked = lv && !e_ly;
      if (m_locked) begin
         if (e_ly && !lk) m_locked = 0;
      end else if (m_forced) begin
         if (e_ly) begin
            m_forced = 0;
            m_locked = lk;
         end else if (!lv) begin
            m_forced = 0;
         end
      end else begin
         if (e_ly && lk) m_locked = 1;
         else if (blocked && m_wait == MAX - 1) m_forced = 1;
      end
      m_wait = blocked ? ((m_wait < MAX) ? m_wait + 1 : MAX) : 0;
   endtask

   task automatic test_reset();
      apply(1, 8'h3C, 1, 8'h5A, 1, 1);
      #2;
      n_checks++;
      if (obs0() !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected %h", obs0(), {OW{1'b0}});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 2; c++) begin
         apply(0, 8'h00, 1, (c == 0) ? 8'h11 : 8'h22, 1, (c == 0));
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL reset_enter_lock c=%0d: got %h expected %h", c, obs0(), e_vec);
         end
         if (c == 0) begin
            @(posedge clk);
            model_advance();
            #1;
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs0() !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_lock: got %h expected %h", obs0(), {OW{1'b0}});
      end
      apply(0, 8'h00, 0, 8'h00, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      model_eval();
      @(negedge clk);
      n_checks++;
      if ({bus.cache_busy_o, bus.starve_cnt_o} !== {1'b0, CW'(0)}) begin
         n_fail++;
         $display("FAIL reset_release: got busy=%b cnt=%0d expected busy=0 cnt=0",
                  bus.cache_busy_o, bus.starve_cnt_o);
      end
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic test_passthrough();
      logic [4+W:0] got, exp;
      for (int c = 0; c < 8; c++) begin
         bit cv;
         cv = (c % 2 == 0);
         apply(cv, 8'hA5, 0, 8'h00, 0, 1);
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL passthrough_model c=%0d: got %h expected %h", c, obs0(), e_vec);
         end
         got = {bus.cache_pkt_yumi_o, bus.lce_pkt_yumi_o, bus.mem_pkt_v_o, bus.mem_sel_lce_o,
                bus.cache_busy_o, bus.mem_pkt_o};
         exp = {cv, 1'b0, cv, 1'b0, 1'b0, 8'hA5};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL passthrough c=%0d: got %h expected %h", c, got, exp);
         end
         @(posedge clk);
         model_advance();
         #1;
      end
   endtask

   task automatic test_contention();
      logic [2+CW:0] got, exp;
      for (int c = 0; c < 10; c++) begin
         apply(1, W'(8'h40 + c), 1, (c < 5) ? 8'h70 : 8'h71, 0, 1);
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL contention_model c=%0d: got %h expected %h", c, obs0(), e_vec);
         end
         got = {bus.cache_pkt_yumi_o, bus.lce_pkt_yumi_o, bus.cache_busy_o, bus.starve_cnt_o};
         exp = {c % 5 != 4, c % 5 == 4, c % 5 == 4, CW'(c % 5)};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL contention c=%0d: got %h expected %h", c, got, exp);
         end
         @(posedge clk);
         model_advance();
         #1;
      end
   endtask

   task automatic test_lock();
      logic [2+CW:0] got, exp;
      for (int c = 0; c < 8; c++) begin
         int k;
         k = (c <= 4) ? 0 : c - 4;
         apply(1, W'(8'h20 + c), c < 7, W'(8'h90 + k), k < 2, 1);
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL lock_model c=%0d: got %h expected %h", c, obs0(), e_vec);
         end
         got = {bus.cache_pkt_yumi_o, bus.lce_pkt_yumi_o, bus.cache_busy_o, bus.starve_cnt_o};
         exp = {(c < 4) || (c == 7), (c >= 4) && (c <= 6), (c >= 4) && (c <= 6),
                CW'((c <= 4) ? c : 0)};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL lock c=%0d: got %h expected %h", c, got, exp);
         end
         @(posedge clk);
         model_advance();
         #1;
      end
   endtask

   task automatic test_backpressure();
      logic [3+CW:0] got, exp;
      for (int c = 0; c < 8; c++) begin
         apply(0, 8'h00, c < 7, 8'hC3, 0, c >= 6);
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL backpressure_model c=%0d: got %h expected %h", c, obs0(), e_vec);
         end
         got = {bus.lce_pkt_yumi_o, bus.mem_pkt_v_o, bus.mem_sel_lce_o, bus.cache_busy_o,
                bus.starve_cnt_o};
         exp = {c == 6, c < 7, c < 7, (c >= 4) && (c <= 6),
                CW'((c < 7) ? ((c < MAX) ? c : MAX) : 0)};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL backpressure c=%0d: got %h expected %h", c, got, exp);
         end
         @(posedge clk);
         model_advance();
         #1;
      end
   endtask

   task automatic test_max1();
      logic [5:0] exp_t [4];
      logic [5:0] got;
      exp_t[0] = 6'b100010;
      exp_t[1] = 6'b001111;
      exp_t[2] = 6'b011111;
      exp_t[3] = 6'b100010;
      for (int c = 0; c < 4; c++) begin
         bus1.cache_pkt_v_i   = 1'b1;
         bus1.cache_pkt_i     = 8'h0F;
         bus1.lce_pkt_v_i     = (c < 3);
         bus1.lce_pkt_i       = 8'hF0;
         bus1.lce_lock_i      = 1'b0;
         bus1.mem_ready_and_i = (c != 1);
         @(negedge clk);
         got = {bus1.cache_pkt_yumi_o, bus1.lce_pkt_yumi_o, bus1.cache_busy_o,
                bus1.starve_cnt_o, bus1.mem_pkt_v_o, bus1.mem_sel_lce_o};
         n_checks++;
         if (got !== exp_t[c]) begin
            n_fail++;
            $display("FAIL max1 c=%0d: got %b expected %b", c, got, exp_t[c]);
         end
         @(posedge clk); #1;
      end
      bus1.cache_pkt_v_i   = 1'b0;
      bus1.lce_pkt_v_i     = 1'b0;
      bus1.mem_ready_and_i = 1'b0;
   endtask

   task automatic test_random();
      bit pend = 0;
      bit lv = 0, lk = 0;
      logic [W-1:0] lp = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            lv = ($urandom_range(0, 99) < 50);
            lp = W'($urandom);
            lk = ($urandom_range(0, 99) < 25);
         end
         apply(1'($urandom_range(0, 1)), W'($urandom), lv, lp, lk, $urandom_range(0, 99) < 70);
         model_eval();
         @(negedge clk);
         n_checks++;
         if (obs0() !== e_vec) begin
            n_fail++;
            $display("FAIL random i=%0d: got %h expected %h", i, obs0(), e_vec);
         end
         @(posedge clk);
         model_advance();
         pend = lv && !e_ly;
         #1;
      end
   endtask

   initial begin
      apply(0, 8'h00, 0, 8'h00, 0, 0);
      bus1.cache_pkt_v_i   = 1'b0;
      bus1.cache_pkt_i     = '0;
      bus1.lce_pkt_v_i     = 1'b0;
      bus1.lce_pkt_i       = '0;
      bus1.lce_lock_i      = 1'b0;
      bus1.mem_ready_and_i = 1'b0;
      model_reset();
      test_reset();
      test_passthrough();
      test_contention();
      test_lock();
      test_backpressure();
      test_max1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
